// File: rtl/fetch_pair_buffer_if.sv
// Handshake bundle between fetch, the pair buffer and the dual-issue relayer.
// master = fetch/relayer side, slave = fetch_pair_buffer.
interface fetch_pair_buffer_if #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          fill_valid;
  logic          fill_ready;
  logic [IW-1:0] fill_instr1;
  logic [IW-1:0] fill_instr2;
  logic [IW-1:0] instr1_o;
  logic [IW-1:0] instr2_o;
  logic          instr1_valid;
  logic          instr2_valid;
  logic          issingleinstr;
  logic          isstall;
  logic [CW-1:0] count_o;

  modport master (
    output flush, fill_valid, fill_instr1, fill_instr2, issingleinstr, isstall,
    input  fill_ready, instr1_o, instr2_o, instr1_valid, instr2_valid, count_o
  );

  modport slave (
    input  flush, fill_valid, fill_instr1, fill_instr2, issingleinstr, isstall,
    output fill_ready, instr1_o, instr2_o, instr1_valid, instr2_valid, count_o
  );
endinterface

// File: rtl/fetch_pair_buffer.sv
// Instruction pair queue: accepts 2 words per fill, retires 0/1/2 words per cycle.
// Optional issue statistics counters enabled by FETCH_PAIR_BUFFER_STATS_EN.
module fetch_pair_buffer #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pair_buffer_if.slave   bus
`ifdef FETCH_PAIR_BUFFER_STATS_EN
  ,
  output logic [15:0]          stall_cnt_o,
  output logic [15:0]          single_cnt_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next, rd_ptr_p1;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next, wr_ptr_p1;
  logic [CW-1:0] count_reg, count_next;
  logic          valid1, valid2;
  logic          wr_en;
  logic [1:0]    retire;

  assign rd_ptr_p1 = rd_ptr_reg + PW'(1);
  assign wr_ptr_p1 = wr_ptr_reg + PW'(1);
  assign valid1    = (count_reg != '0);
  assign valid2    = (count_reg >= CW'(2));

  // Ready depends on stored count only, so freed slots become usable next cycle.
  assign bus.fill_ready = (count_reg <= CW'(DEPTH - 2));
  assign wr_en          = bus.fill_valid && bus.fill_ready;

  always_comb begin
    retire = 2'd0;
    if (!valid1 || bus.isstall) begin
      retire = 2'd0;
    end else if (bus.issingleinstr || !valid2) begin
      retire = 2'd1;
    end else begin
      retire = 2'd2;
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(retire);
    wr_ptr_next = wr_en ? (wr_ptr_reg + PW'(2)) : wr_ptr_reg;
    count_next  = count_reg - CW'(retire) + (wr_en ? CW'(2) : CW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset: invalid slots are masked to NOP on the outputs.
  always_ff @(posedge clk) begin
    if (wr_en && !bus.flush && !rst) begin
      mem[wr_ptr_reg] <= bus.fill_instr1;
      mem[wr_ptr_p1]  <= bus.fill_instr2;
    end
  end

  assign bus.instr1_o     = valid1 ? mem[rd_ptr_reg] : '0;
  assign bus.instr2_o     = valid2 ? mem[rd_ptr_p1]  : '0;
  assign bus.instr1_valid = valid1;
  assign bus.instr2_valid = valid2;
  assign bus.count_o      = count_reg;

`ifdef FETCH_PAIR_BUFFER_STATS_EN
  logic [15:0] stall_cnt_reg, single_cnt_reg;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      single_cnt_reg <= '0;
    end else begin
      if (valid1 && bus.isstall && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if ((retire == 2'd1) && (single_cnt_reg != 16'hFFFF)) begin
        single_cnt_reg <= single_cnt_reg + 16'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_reg;
  assign single_cnt_o = single_cnt_reg;
`endif
endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Directed + randomized bench for fetch_pair_buffer against a word-queue model.
// Statistics ports are connected and checked when FETCH_PAIR_BUFFER_STATS_EN is defined.
module tb_fetch_pair_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pair_buffer_if #(.DEPTH(DEPTH), .IW(16)) bus ();

`ifdef FETCH_PAIR_BUFFER_STATS_EN
  logic [15:0] stall_cnt_o, single_cnt_o;
  fetch_pair_buffer #(.DEPTH(DEPTH), .IW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_cnt_o(stall_cnt_o), .single_cnt_o(single_cnt_o)
  );
`else
  fetch_pair_buffer #(.DEPTH(DEPTH), .IW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  logic [15:0] q [$];
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int stall_m   = 0;
  int single_m  = 0;
  logic [15:0] exp5 [8] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                            16'hEEEE, 16'hFFFF, 16'h1111, 16'h2222};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic fv, input logic [15:0] w1, input logic [15:0] w2,
                       input logic iss, input logic stl, input logic fl, input logic r);
    bus.fill_valid    = fv;
    bus.fill_instr1   = w1;
    bus.fill_instr2   = w2;
    bus.issingleinstr = iss;
    bus.isstall       = stl;
    bus.flush         = fl;
    rst               = r;
  endtask

  // Compare every output against the queue model and print one line per transaction.
  task automatic check_model(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},  32'(bus.count_o),      32'(n));
    check({tag, ".instr1"}, 32'(bus.instr1_o),     (n >= 1) ? 32'(q[0]) : 32'h0);
    check({tag, ".instr2"}, 32'(bus.instr2_o),     (n >= 2) ? 32'(q[1]) : 32'h0);
    check({tag, ".valid1"}, 32'(bus.instr1_valid), 32'(n >= 1));
    check({tag, ".valid2"}, 32'(bus.instr2_valid), 32'(n >= 2));
    check({tag, ".ready"},  32'(bus.fill_ready),   32'(n <= DEPTH - 2));
`ifdef FETCH_PAIR_BUFFER_STATS_EN
    check({tag, ".stall_cnt"},  32'(stall_cnt_o),  32'(stall_m));
    check({tag, ".single_cnt"}, 32'(single_cnt_o), 32'(single_m));
`endif
    $display("%0t %s: count=%0d i1=%h i2=%h", $time, tag, bus.count_o, bus.instr1_o, bus.instr2_o);
  endtask

  // Advance the model by the rules for the current inputs, then clock the DUT.
  task automatic tick();
    int n;
    int r;
    logic [15:0] tmp;
    n = q.size();
    if (rst) begin
      q.delete();
      stall_m  = 0;
      single_m = 0;
    end else begin
      if (n == 0)                                    r = 0;
      else if (bus.isstall)                          r = 0;
      else if (bus.issingleinstr || n < 2)           r = 1;
      else                                           r = 2;
      if (n > 0 && bus.isstall && stall_m < 65535)   stall_m++;
      if (r == 1 && single_m < 65535)                single_m++;
      if (bus.flush) begin
        q.delete();
      end else begin
        for (int k = 0; k < r; k++) tmp = q.pop_front();
        if (bus.fill_valid && n <= DEPTH - 2) begin
          q.push_back(bus.fill_instr1);
          q.push_back(bus.fill_instr2);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive(0, 16'h0, 16'h0, 0, 0, 0, 1);
    @(negedge clk);

    // 1: reset state
    tick(); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0);
    check("t1.count",  32'(bus.count_o), 32'd0);
    check("t1.instr1", 32'(bus.instr1_o), 32'h0);
    check("t1.instr2", 32'(bus.instr2_o), 32'h0);
    check("t1.valid1", 32'(bus.instr1_valid), 32'd0);
    check("t1.valid2", 32'(bus.instr2_valid), 32'd0);
    check("t1.ready",  32'(bus.fill_ready), 32'd1);
    check_model("t1");

    // 2: fill then dual retire
    drive(1, 16'h1234, 16'h5678, 0, 0, 0, 0); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0);
    check("t2.instr1", 32'(bus.instr1_o), 32'h1234);
    check("t2.instr2", 32'(bus.instr2_o), 32'h5678);
    tick();
    check("t2.count", 32'(bus.count_o), 32'd0);

    // 3: single issue slides instr2 forward
    drive(1, 16'h1234, 16'h5678, 0, 0, 0, 0); tick();
    drive(0, 16'h0, 16'h0, 1, 0, 0, 0); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0);
    check("t3.instr1", 32'(bus.instr1_o), 32'h5678);
    check("t3.valid2", 32'(bus.instr2_valid), 32'd0);
    check("t3.count",  32'(bus.count_o), 32'd1);
    tick();
    check_model("t3");

    // 4: stall overrides single issue
    drive(1, 16'h8F34, 16'h8F78, 0, 0, 0, 0); tick();
    drive(0, 16'h0, 16'h0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("t4.instr1", 32'(bus.instr1_o), 32'h8F34);
      check("t4.instr2", 32'(bus.instr2_o), 32'h8F78);
      check("t4.count",  32'(bus.count_o), 32'd2);
      tick();
    end
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0); tick();
    check("t4.drain", 32'(bus.count_o), 32'd0);

    // 5: fill to full, drop 5th pair, drain across pointer wrap
    for (int k = 0; k < 4; k++) begin
      drive(1, exp5[2*k], exp5[2*k+1], 0, 1, 0, 0); tick();
    end
    check("t5.full_count", 32'(bus.count_o), 32'd8);
    check("t5.full_ready", 32'(bus.fill_ready), 32'd0);
    drive(1, 16'h3333, 16'h4444, 0, 1, 0, 0); tick();
    check("t5.drop_count", 32'(bus.count_o), 32'd8);
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("t5.instr1", 32'(bus.instr1_o), 32'(exp5[2*k]));
      check("t5.instr2", 32'(bus.instr2_o), 32'(exp5[2*k+1]));
      tick();
    end
    check("t5.empty", 32'(bus.count_o), 32'd0);

    // 6: flush with concurrent fill discards everything
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'(k + 16'h0100), 16'(k + 16'h0200), 0, 1, 0, 0); tick();
    end
    check("t6.pre_count", 32'(bus.count_o), 32'd6);
    drive(1, 16'h7777, 16'h8888, 0, 1, 1, 0); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0);
    check("t6.count",  32'(bus.count_o), 32'd0);
    check("t6.valid1", 32'(bus.instr1_valid), 32'd0);
    check("t6.valid2", 32'(bus.instr2_valid), 32'd0);
    check_model("t6");

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      check_model("rnd");
      tick();
    end
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0);
    check_model("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
